register_file_access_arbiter: RTL and testbench

REGISTER_FILE_ACCESS_ARBITER -- requirements
Module: register_file_access_arbiter

---
 rtl/register_file_access_pkg.sv | 19 +
 rtl/round_robin_arbiter.sv | 32 +++
 rtl/register_file_access_arbiter.sv | 141 ++++++++++++++
 tb/tb_register_file_access_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_access_pkg.sv
// Shared types and default sizing for the register-file access arbiter.
// The arbiter either sweeps the whole file to zero (CLEAR) or serves requesters (SERVE).
package register_file_access_pkg;

  localparam int DEFAULT_NUMBER_OF_REGISTERS  = 256;
  localparam int DEFAULT_NUMBER_OF_REQUESTERS = 4;
  localparam int DATA_WIDTH                   = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } arbiter_state_e;

  // A single requester still needs a one-bit pointer register.
  function automatic int pointer_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin grant: search starts at pointer, first requester found wins,
// and the pointer advances to one past the winner. No request leaves the pointer unchanged.
module round_robin_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_pointer
);

  logic found;

  function automatic int wrap_index(input int base, input int offset);
    return (base + offset) % N;
  endfunction

  always_comb begin
    grant        = '0;
    next_pointer = pointer;
    found        = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && request[PW'(wrap_index(int'(pointer), k))]) begin
        found                                      = 1'b1;
        grant[PW'(wrap_index(int'(pointer), k))]   = 1'b1;
        next_pointer = PW'(wrap_index(int'(pointer), k + 1));
      end
    end
  end

endmodule

// File: rtl/register_file_access_arbiter.sv
// Arbitrates N requesters onto one register-file write port and one read port, and
// zeroes the whole file after reset or on demand before any requester is served.
module register_file_access_arbiter
  import register_file_access_pkg::*;
#(
  parameter int NUMBER_OF_REGISTERS  = DEFAULT_NUMBER_OF_REGISTERS,
  parameter int NUMBER_OF_REQUESTERS = DEFAULT_NUMBER_OF_REQUESTERS
) (
  input  logic                                                clock_in,
  input  logic                                                reset_n_in,
  input  logic [NUMBER_OF_REQUESTERS-1:0]                     request_valid_in,
  input  logic [NUMBER_OF_REQUESTERS-1:0]                     request_write_in,
  input  logic [NUMBER_OF_REQUESTERS*$clog2(NUMBER_OF_REGISTERS)-1:0] request_address_in,
  input  logic [NUMBER_OF_REQUESTERS*DATA_WIDTH-1:0]          request_write_data_in,
  output logic [NUMBER_OF_REQUESTERS-1:0]                     request_ready_out,
  output logic [NUMBER_OF_REQUESTERS-1:0]                     response_valid_out,
  output logic [DATA_WIDTH-1:0]                               response_read_data_out,
  input  logic                                                clear_start_in,
  output logic                                                busy_out,
  output logic                                                state_out,
  output logic                                                rf_write_enable_out,
  output logic [$clog2(NUMBER_OF_REGISTERS)-1:0]              rf_write_register_address_out,
  output logic [DATA_WIDTH-1:0]                               rf_write_data_out,
  output logic [$clog2(NUMBER_OF_REGISTERS)-1:0]              rf_read_register_address1_out,
  input  logic [DATA_WIDTH-1:0]                               rf_read_data1_in
);

  localparam int N  = NUMBER_OF_REQUESTERS;
  localparam int A  = $clog2(NUMBER_OF_REGISTERS);
  localparam int PW = pointer_width(NUMBER_OF_REQUESTERS);
  localparam logic [A-1:0] LAST_ADDRESS = A'(NUMBER_OF_REGISTERS - 1);

  // Handshake: a requester's access transfers in the cycle where its
  // request_valid_in and request_ready_out bits are both high; ready never
  // depends on ready, only on valid, pointer, state and clear_start_in.

  arbiter_state_e       state_q, state_d;
  logic [A-1:0]         clear_count_q;
  logic [PW-1:0]        pointer_q, pointer_next;
  logic [N-1:0]         response_valid_q;
  logic [DATA_WIDTH-1:0] response_data_q;

  logic [N-1:0]          arb_request;
  logic [N-1:0]          grant;
  logic [N-1:0]          read_grant;
  logic                  any_grant;
  logic                  sel_write;
  logic [A-1:0]          sel_address;
  logic [DATA_WIDTH-1:0] sel_data;

  // A clear request in SERVE suppresses arbitration entirely for that cycle.
  assign arb_request = (state_q == SERVE && !clear_start_in) ? request_valid_in : '0;

  round_robin_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_round_robin_arbiter (
    .request      (arb_request),
    .pointer      (pointer_q),
    .grant        (grant),
    .next_pointer (pointer_next)
  );

  assign any_grant  = |grant;
  assign read_grant = grant & ~request_write_in;

  always_comb begin
    sel_write   = 1'b0;
    sel_address = '0;
    sel_data    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_write   = request_write_in[i];
        sel_address = request_address_in[i*A +: A];
        sel_data    = request_write_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d                       = state_q;
    request_ready_out             = '0;
    busy_out                      = 1'b0;
    rf_write_enable_out           = 1'b0;
    rf_write_register_address_out = '0;
    rf_write_data_out             = '0;
    rf_read_register_address1_out = sel_address;
    case (state_q)
      CLEAR: begin
        busy_out                      = 1'b1;
        rf_write_enable_out           = 1'b1;
        rf_write_register_address_out = clear_count_q;
        if (clear_count_q == LAST_ADDRESS) begin
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (clear_start_in) begin
          state_d = CLEAR;
        end else begin
          request_ready_out = grant;
          if (any_grant && sel_write) begin
            rf_write_enable_out           = 1'b1;
            rf_write_register_address_out = sel_address;
            rf_write_data_out             = sel_data;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q          <= CLEAR;
      clear_count_q    <= '0;
      pointer_q        <= '0;
      response_valid_q <= '0;
      response_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      pointer_q <= pointer_next;
      // Counter parks at zero outside CLEAR so every clear starts from address 0.
      if (state_q == CLEAR && state_d == CLEAR) begin
        clear_count_q <= clear_count_q + A'(1);
      end else begin
        clear_count_q <= '0;
      end
      // Read responses complete even if CLEAR begins on the same edge.
      response_valid_q <= read_grant;
      if (|read_grant) begin
        response_data_q <= rf_read_data1_in;
      end
    end
  end

  assign response_valid_out     = response_valid_q;
  assign response_read_data_out = response_data_q;
  assign state_out              = (state_q == SERVE);

endmodule

// File: tb/tb_register_file_access_arbiter.sv
// Directed bench for register_file_access_arbiter with a behavioural 256x8 register file.
module tb_register_file_access_arbiter;

  logic        clock_in = 1'b0;
  logic        reset_n_in;
  logic [3:0]  request_valid_in;
  logic [3:0]  request_write_in;
  logic [31:0] request_address_in;
  logic [31:0] request_write_data_in;
  logic [3:0]  request_ready_out;
  logic [3:0]  response_valid_out;
  logic [7:0]  response_read_data_out;
  logic        clear_start_in;
  logic        busy_out;
  logic        state_out;
  logic        rf_write_enable_out;
  logic [7:0]  rf_write_register_address_out;
  logic [7:0]  rf_write_data_out;
  logic [7:0]  rf_read_register_address1_out;
  logic [7:0]  rf_read_data1_in;

  logic [7:0]  rf_mem [256];
  logic [7:0]  exp_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;

  register_file_access_arbiter dut (
    .clock_in                      (clock_in),
    .reset_n_in                    (reset_n_in),
    .request_valid_in              (request_valid_in),
    .request_write_in              (request_write_in),
    .request_address_in            (request_address_in),
    .request_write_data_in         (request_write_data_in),
    .request_ready_out             (request_ready_out),
    .response_valid_out            (response_valid_out),
    .response_read_data_out        (response_read_data_out),
    .clear_start_in                (clear_start_in),
    .busy_out                      (busy_out),
    .state_out                     (state_out),
    .rf_write_enable_out           (rf_write_enable_out),
    .rf_write_register_address_out (rf_write_register_address_out),
    .rf_write_data_out             (rf_write_data_out),
    .rf_read_register_address1_out (rf_read_register_address1_out),
    .rf_read_data1_in              (rf_read_data1_in)
  );

  // clock/reset block
  initial forever #5 clock_in = ~clock_in;

  always @(posedge clock_in) begin
    if (rf_write_enable_out) rf_mem[rf_write_register_address_out] <= rf_write_data_out;
  end
  assign rf_read_data1_in = rf_mem[rf_read_register_address1_out];

  // driver tasks
  task automatic cycle();
    @(negedge clock_in);
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    request_write_in[i]            = w;
    request_address_in[i*8 +: 8]    = a;
    request_write_data_in[i*8 +: 8] = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Requesters hammer the port with writes and clear_start is poked during CLEAR;
  // every cycle must still be a zero-write to the next sequential address.
  task automatic run_clear(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      cycle();
      request_valid_in      = 4'hF;
      request_write_in      = 4'hF;
      request_write_data_in = 32'hFFFF_FFFF;
      clear_start_in        = (k == 50 || k == 255);
      #1;
      check("clear_cycle",
            {busy_out, rf_write_enable_out, rf_write_register_address_out, rf_write_data_out, request_ready_out},
            {1'b1, 1'b1, 8'(k), 8'h00, 4'h0});
      clear_start_in   = 1'b0;
      request_valid_in = 4'h0;
    end
  endtask

  initial begin
    reset_n_in            = 1'b0;
    clear_start_in        = 1'b0;
    request_valid_in      = 4'hF;
    request_write_in      = 4'h0;
    request_address_in    = '0;
    request_write_data_in = '0;
    repeat (2) cycle();
    #1;
    check("reset_busy", busy_out, 1);
    check("reset_state", state_out, 0);
    check("reset_ready", request_ready_out, 0);
    check("reset_resp_valid", response_valid_out, 0);
    check("reset_resp_data", response_read_data_out, 0);
    request_valid_in = 4'h0;
    @(posedge clock_in); #2 reset_n_in = 1'b1;

    // initial clear, then SERVE
    run_clear(256);
    cycle(); #1;
    check("serve_after_clear", {busy_out, state_out, rf_write_enable_out}, 3'b010);

    // all four request together, each drops after its grant
    for (int i = 0; i < 4; i++) begin
      cycle();
      for (int j = 0; j < 4; j++) set_req(j, 1'b1, 8'h30 + 8'(j), 8'h40 + 8'(j));
      request_valid_in = 4'hF << i;
      #1;
      check("rr_all_ready", request_ready_out, 4'b0001 << i);
      check("rr_all_write", {rf_write_enable_out, rf_write_register_address_out, rf_write_data_out},
            {1'b1, 8'h30 + 8'(i), 8'h40 + 8'(i)});
    end

    // requesters 0 and 2 write continuously
    for (int i = 0; i < 4; i++) begin
      cycle();
      request_write_in = 4'h0;
      set_req(0, 1'b1, 8'h20, 8'h11);
      set_req(2, 1'b1, 8'h22, 8'h33);
      request_valid_in = 4'b0101;
      #1;
      check("rr_pair_ready", request_ready_out, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      check("rr_pair_addr", rf_write_register_address_out, (i % 2 == 0) ? 8'h20 : 8'h22);
    end

    // write A5 to 0x10 from requester 1, read it back through requester 3
    cycle();
    request_write_in = 4'h0;
    set_req(1, 1'b1, 8'h10, 8'hA5);
    request_valid_in = 4'b0010;
    #1;
    check("wr1_ready", request_ready_out, 4'b0010);
    check("wr1_port", {rf_write_enable_out, rf_write_register_address_out, rf_write_data_out}, {1'b1, 8'h10, 8'hA5});
    cycle();
    request_write_in = 4'h0;
    set_req(3, 1'b0, 8'h10, 8'h00);
    request_valid_in = 4'b1000;
    #1;
    check("rd3_ready", request_ready_out, 4'b1000);
    check("rd3_port", {rf_write_enable_out, rf_read_register_address1_out}, {1'b0, 8'h10});
    exp_q.push_back(8'hA5);
    cycle();
    request_valid_in = 4'h0;
    #1;
    check("rd3_resp_valid", response_valid_out, 4'b1000);
    check("rd3_resp_data", response_read_data_out, exp_q.pop_front());
    cycle(); #1;
    check("resp_valid_one_cycle", response_valid_out, 4'b0000);
    check("resp_data_hold", response_read_data_out, 8'hA5);

    // read of earlier round-robin write (0x32 holds 0x42)
    cycle();
    set_req(2, 1'b0, 8'h32, 8'h00);
    request_valid_in = 4'b0100;
    #1;
    check("rd2_ready", request_ready_out, 4'b0100);
    exp_q.push_back(8'h42);
    cycle();
    request_valid_in = 4'h0;
    #1;
    check("rd2_resp_valid", response_valid_out, 4'b0100);
    check("rd2_resp_data", response_read_data_out, exp_q.pop_front());

    // read granted the cycle before clear_start still responds
    cycle();
    request_write_in = 4'h0;
    set_req(0, 1'b0, 8'h10, 8'h00);
    request_valid_in = 4'b0001;
    #1;
    check("rd0_ready", request_ready_out, 4'b0001);
    check("rd0_raddr", rf_read_register_address1_out, 8'h10);
    exp_q.push_back(8'hA5);
    cycle();
    clear_start_in = 1'b1;
    #1;
    check("clear_start_blocks_grant", {request_ready_out, rf_write_enable_out}, 5'b0);
    check("rd0_resp_valid", response_valid_out, 4'b0001);
    check("rd0_resp_data", response_read_data_out, exp_q.pop_front());
    run_clear(256);
    cycle();
    request_write_in = 4'h0;
    set_req(1, 1'b0, 8'h10, 8'h00);
    request_valid_in = 4'b0010;
    #1;
    check("post_clear_serve", {busy_out, request_ready_out}, 5'b00010);
    exp_q.push_back(8'h00);
    cycle();
    request_valid_in = 4'h0;
    #1;
    check("post_clear_resp_valid", response_valid_out, 4'b0010);
    check("post_clear_resp_data", response_read_data_out, exp_q.pop_front());

    // leave pointer at 2 and non-zero read data, then reset mid-clear
    cycle();
    request_write_in = 4'h0;
    set_req(0, 1'b1, 8'h20, 8'h77);
    request_valid_in = 4'b0001;
    #1;
    check("wr0_ready", request_ready_out, 4'b0001);
    cycle();
    request_write_in = 4'h0;
    set_req(1, 1'b0, 8'h20, 8'h00);
    request_valid_in = 4'b0010;
    #1;
    check("rd1_ready", request_ready_out, 4'b0010);
    exp_q.push_back(8'h77);
    cycle();
    request_valid_in = 4'h0;
    clear_start_in   = 1'b1;
    #1;
    check("rd1_resp_data", response_read_data_out, exp_q.pop_front());
    run_clear(101);
    reset_n_in = 1'b0;
    #1;
    check("midclear_reset_port",
          {busy_out, state_out, rf_write_enable_out, rf_write_register_address_out}, {3'b101, 8'h00});
    check("midclear_reset_resp", {response_valid_out, response_read_data_out}, 12'h000);
    @(posedge clock_in); #2 reset_n_in = 1'b1;
    run_clear(256);
    cycle();
    request_write_in = 4'h0;
    set_req(1, 1'b1, 8'h50, 8'h01);
    set_req(3, 1'b1, 8'h53, 8'h03);
    request_valid_in = 4'b1010;
    #1;
    check("pointer_reset", request_ready_out, 4'b0010);
    cycle();
    request_valid_in = 4'h0;

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
